// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: jump/branch resolution with registered pc redirect, squash shadow and link write
module branch_resolve_unit #(
  parameter int XLEN = 32,
  parameter int PC_DELAY = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int WORD_PC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] src1_value,
  input  logic [XLEN-1:0] src2_value,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd,
  input  logic [3:0]      jb_op,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            misalign_exc,
  output logic            write_req,
  output logic [4:0]      write_addr,
  output logic [XLEN-1:0] write_data
);
  localparam logic [XLEN-1:0] STEP = WORD_PC != 0 ? XLEN'(1) : XLEN'(4);
  logic [XLEN-1:0] pc_pipe_q [PC_DELAY];
  logic [XLEN-1:0] pc_dly, off, jt, tgt, link;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d, write_data_q, write_data_d;
  logic [4:0] write_addr_q, write_addr_d;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic redirect_valid_q, redirect_valid_d, misalign_exc_q, misalign_exc_d, write_req_q, write_req_d;
  logic is_jmp, taken, ft, mis, squash, go;
  always_comb begin
    pc_dly = pc_pipe_q[PC_DELAY-1];
    off = WORD_PC != 0 ? $unsigned($signed(imm) >>> 2) : imm;
    jt = (src1_value + imm) & ~XLEN'(1);
    is_jmp = jb_op == 4'd1 || jb_op == 4'd2;
    taken = is_jmp
      || (jb_op == 4'd3 && src1_value == src2_value)
      || (jb_op == 4'd4 && src1_value != src2_value)
      || (jb_op == 4'd5 && $signed(src1_value) < $signed(src2_value))
      || (jb_op == 4'd6 && $signed(src1_value) >= $signed(src2_value))
      || (jb_op == 4'd7 && src1_value < src2_value)
      || (jb_op == 4'd8 && src1_value >= src2_value);
    tgt = jb_op == 4'd2 ? (WORD_PC != 0 ? $unsigned($signed(jt) >>> 2) : jt) : pc_dly + off;
    ft = tgt == pc_dly + STEP;
    mis = WORD_PC == 0 && tgt[1:0] != 2'b00;
    squash = redirect_valid_q || flush_cnt_q != '0;
    go = taken && !squash && !ft;
    redirect_valid_d = go && !mis;
    misalign_exc_d = go && mis;
    write_req_d = is_jmp && !squash && rd != 5'd0 && !(go && mis);
    link = WORD_PC != 0 ? (pc_dly + XLEN'(1)) << 2 : pc_dly + XLEN'(4);
    redirect_pc_d = redirect_valid_d ? tgt : redirect_pc_q;
    write_addr_d = write_req_d ? rd : write_addr_q;
    write_data_d = write_req_d ? link : write_data_q;
    flush_cnt_d = redirect_valid_q ? 4'(FLUSH_CYCLES - 1) : flush_cnt_q != '0 ? flush_cnt_q - 4'd1 : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PC_DELAY; i++) pc_pipe_q[i] <= '0;
      flush_cnt_q <= '0;
      redirect_valid_q <= 1'b0;
      misalign_exc_q <= 1'b0;
      write_req_q <= 1'b0;
      redirect_pc_q <= '0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      pc_pipe_q[0] <= pc;
      for (int i = 1; i < PC_DELAY; i++) pc_pipe_q[i] <= pc_pipe_q[i-1];
      flush_cnt_q <= flush_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      misalign_exc_q <= misalign_exc_d;
      write_req_q <= write_req_d;
      redirect_pc_q <= redirect_pc_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc = redirect_pc_q;
  assign misalign_exc = misalign_exc_q;
  assign write_req = write_req_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed checks of word-mode, byte-mode and long-shadow instances
module tb_branch_resolve_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] pc, s1, s2, imm;
  logic [4:0] rd;
  logic [3:0] op;
  logic w_rv, w_exc, w_wr, b_rv, b_exc, b_wr, f_rv, f_exc, f_wr;
  logic [31:0] w_rpc, w_wd, b_rpc, b_wd, f_rpc, f_wd;
  logic [4:0] w_wa, b_wa, f_wa;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  branch_resolve_unit u_w (.clk(clk), .reset(reset), .pc(pc), .src1_value(s1), .src2_value(s2), .imm(imm), .rd(rd), .jb_op(op),
    .redirect_valid(w_rv), .redirect_pc(w_rpc), .misalign_exc(w_exc), .write_req(w_wr), .write_addr(w_wa), .write_data(w_wd));
  branch_resolve_unit #(.WORD_PC(0)) u_b (.clk(clk), .reset(reset), .pc(pc), .src1_value(s1), .src2_value(s2), .imm(imm), .rd(rd), .jb_op(op),
    .redirect_valid(b_rv), .redirect_pc(b_rpc), .misalign_exc(b_exc), .write_req(b_wr), .write_addr(b_wa), .write_data(b_wd));
  branch_resolve_unit #(.FLUSH_CYCLES(3)) u_f (.clk(clk), .reset(reset), .pc(pc), .src1_value(s1), .src2_value(s2), .imm(imm), .rd(rd), .jb_op(op),
    .redirect_valid(f_rv), .redirect_pc(f_rpc), .misalign_exc(f_exc), .write_req(f_wr), .write_addr(f_wa), .write_data(f_wd));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] i, input logic [4:0] r);
    op = o;
    s1 = a;
    s2 = b;
    imm = i;
    rd = r;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
  endtask
  initial begin
    pc = 32'h10;
    idle(2);
    check("rst_rv", {31'd0, w_rv}, 32'd0);
    check("rst_rpc", w_rpc, 32'd0);
    check("rst_wr", {31'd0, w_wr}, 32'd0);
    check("rst_wd", w_wd, 32'd0);
    reset = 1'b0;
    idle(4);
    apply(4'd3, 32'd5, 32'd5, 32'h20, 5'd0);
    check("beq_rv", {31'd0, w_rv}, 32'd1);
    check("beq_rpc", w_rpc, 32'h18);
    check("beq_wr", {31'd0, w_wr}, 32'd0);
    check("beq_byte_rpc", b_rpc, 32'h30);
    idle(1);
    check("rv_pulse", {31'd0, w_rv}, 32'd0);
    check("rpc_hold", w_rpc, 32'h18);
    idle(3);
    apply(4'd1, 32'd0, 32'd0, 32'd4, 5'd1);
    check("jal_ft_rv", {31'd0, w_rv}, 32'd0);
    check("jal_wr", {31'd0, w_wr}, 32'd1);
    check("jal_wa", {27'd0, w_wa}, 32'd1);
    check("jal_wd", w_wd, 32'h44);
    check("jal_byte_rv", {31'd0, b_rv}, 32'd0);
    check("jal_byte_wd", b_wd, 32'h14);
    idle(4);
    apply(4'd2, 32'h1003, 32'd0, 32'd2, 5'd5);
    check("jalr_rv", {31'd0, b_rv}, 32'd1);
    check("jalr_rpc", b_rpc, 32'h1004);
    check("jalr_wr", {31'd0, b_wr}, 32'd1);
    idle(4);
    apply(4'd2, 32'h1003, 32'd0, 32'd0, 5'd5);
    check("mis_exc", {31'd0, b_exc}, 32'd1);
    check("mis_rv", {31'd0, b_rv}, 32'd0);
    check("mis_wr", {31'd0, b_wr}, 32'd0);
    check("mis_wd_hold", b_wd, 32'h14);
    idle(1);
    check("exc_pulse", {31'd0, b_exc}, 32'd0);
    idle(3);
    apply(4'd4, 32'd1, 32'd2, 32'h20, 5'd0);
    check("bne_rv", {31'd0, f_rv}, 32'd1);
    check("bne_rpc", f_rpc, 32'h18);
    apply(4'd7, 32'd1, 32'd2, 32'h40, 5'd0);
    check("sq1_f", {31'd0, f_rv}, 32'd0);
    check("sq1_w", {31'd0, w_rv}, 32'd0);
    apply(4'd7, 32'd1, 32'd2, 32'h40, 5'd0);
    check("sq2_f", {31'd0, f_rv}, 32'd0);
    check("b2b_w_rv", {31'd0, w_rv}, 32'd1);
    check("b2b_w_rpc", w_rpc, 32'h20);
    apply(4'd7, 32'd1, 32'd2, 32'h40, 5'd0);
    check("sq3_f", {31'd0, f_rv}, 32'd0);
    check("sq3_w", {31'd0, w_rv}, 32'd0);
    apply(4'd7, 32'd1, 32'd2, 32'h40, 5'd0);
    check("resume_rv", {31'd0, f_rv}, 32'd1);
    check("resume_rpc", f_rpc, 32'h20);
    idle(4);
    apply(4'd5, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd0);
    check("blt_rv", {31'd0, w_rv}, 32'd1);
    check("blt_rpc", w_rpc, 32'h18);
    idle(4);
    apply(4'd7, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd0);
    check("bltu_rv", {31'd0, w_rv}, 32'd0);
    idle(1);
    apply(4'd1, 32'd0, 32'd0, 32'h40, 5'd0);
    check("jal_x0_rv", {31'd0, w_rv}, 32'd1);
    check("jal_x0_rpc", w_rpc, 32'h20);
    check("jal_x0_wr", {31'd0, w_wr}, 32'd0);
    idle(4);
    apply(4'd3, 32'd5, 32'd5, 32'h20, 5'd0);
    check("pre_rst_rv", {31'd0, f_rv}, 32'd1);
    idle(1);
    reset = 1'b1;
    idle(1);
    check("mid_rst_rv", {31'd0, f_rv}, 32'd0);
    check("mid_rst_rpc", f_rpc, 32'd0);
    check("mid_rst_wa", {27'd0, f_wa}, 32'd0);
    check("mid_rst_wd", f_wd, 32'd0);
    reset = 1'b0;
    apply(4'd3, 32'd5, 32'd5, 32'h20, 5'd0);
    check("post_rst_rv", {31'd0, f_rv}, 32'd1);
    check("post_rst_rpc", f_rpc, 32'h8);
    idle(4);
    apply(4'd3, 32'd5, 32'd5, 32'h20, 5'd0);
    check("aligned_rv", {31'd0, f_rv}, 32'd1);
    check("aligned_rpc", f_rpc, 32'h18);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised jump/branch resolution stage. Resolves JAL, JALR and the six conditional branches against forwarded operands, and emits a registered PC redirect plus a link-register write request.
- Sits after operand read. Feeds the fetch redirect and the register-file write arbiter.
- Over the previous generation it adds:
  - configurable data width;
  - configurable PC alignment delay;
  - configurable multi-cycle squash shadow after a redirect;
  - word- or byte-addressed PC mode;
  - misaligned-target detection;
  - suppression of link writes to x0.

Parameters:
- XLEN, 32, data/PC width in bits (≥8).
- PC_DELAY, 3, depth of the pc delay line aligning fetch PC to the op in this stage (1..8).
- FLUSH_CYCLES, 1, cycles incoming ops are squashed, counted from the cycle redirect_valid is high (1..15).
- WORD_PC, 1, 1 = pc counts 32-bit words; 0 = pc is a byte address.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  XLEN  fetch PC, delayed internally by PC_DELAY cycles.
- src1_value  in  XLEN  rs1 operand.
- src2_value  in  XLEN  rs2 operand.
- imm  in  XLEN  sign-extended byte offset.
- rd  in  5  link destination register.
- jb_op  in  4  0 none, 1 JAL, 2 JALR, 3 BEQ, 4 BNE, 5 BLT, 6 BGE, 7 BLTU, 8 BGEU, 9..15 treated as none.
- redirect_valid  out  1  one-cycle redirect request.
- redirect_pc  out  XLEN  redirect target, in pc units.
- misalign_exc  out  1  target not 4-byte aligned (byte mode only).
- write_req  out  1  link write request.
- write_addr  out  5  link register index.
- write_data  out  XLEN  link value, byte address.

Behaviour:
- Reset:
  - Delay line, squash counter and all outputs go to 0 on the first clk edge with reset=1.
  - Reset asserted during a squash shadow clears the shadow immediately.
- Latency:
  - All outputs are registered, 1 cycle after the op is presented.
  - pc_d = pc delayed by PC_DELAY registers; the delay line shifts every cycle and never stalls.
- Offset and step:
  - WORD_PC=1: off = imm >>> 2 (arithmetic), step = 1.
  - WORD_PC=0: off = imm, step = 4.
  - All adds wrap modulo 2^XLEN.
- Targets:
  - JAL and branches: tgt = pc_d + off.
  - JALR: t = (src1_value + imm) & ~1; tgt = WORD_PC ? t >>> 2 : t.
- Conditions:
  - BEQ/BNE compare equal / not equal.
  - BLT/BGE compare signed.
  - BLTU/BGEU compare unsigned.
  - JAL and JALR are always taken.
- Squash:
  - squash = redirect_valid | (flush_cnt != 0).
  - On a redirect, flush_cnt loads FLUSH_CYCLES−1; otherwise it decrements while nonzero.
  - A squashed op produces no redirect, no write and no exception.
- Redirect rule: for a non-squashed taken op, redirect_valid=1 and redirect_pc=tgt, except in these two cases:
  - Fall-through: tgt == pc_d + step. Then there is no redirect (a taken branch to the next instruction is not a redirect).
  - Misaligned target: WORD_PC=0 and tgt[1:0] != 0. Then misalign_exc=1, there is no redirect and no write. The fall-through check takes priority.
- Link write:
  - For a non-squashed JAL/JALR: write_req = (rd != 0), write_addr = rd.
  - write_data = WORD_PC ? (pc_d+1) << 2 : pc_d + 4.
  - The link write happens even when the redirect is suppressed as fall-through.
- Register hold/clear:
  - redirect_pc, write_addr and write_data hold their last value when their valid is low.
  - redirect_valid, write_req and misalign_exc are single-cycle pulses, cleared the next cycle unless re-asserted.
- Back-to-back: an op presented in the cycle redirect_valid=1 is always squashed, for any FLUSH_CYCLES.
- None/illegal jb_op: all pulses 0. Does not affect flush_cnt except the normal decrement.

Test Plan:
- Default params; pc_d=0x10, BEQ, src1=src2=5, imm=0x20 → next cycle redirect_valid=1, redirect_pc=0x18, write_req=0.
- Default params; JAL, rd=1, imm=4, pc_d=0x10 → redirect_valid=0 (fall-through), write_req=1, write_addr=1, write_data=0x44.
- WORD_PC=0; JALR, src1=0x1003, imm=0x2 → tgt 0x1004 (not fall-through), redirect_pc=0x1004; with imm=0 → t=0x1002, misalign_exc=1, redirect_valid=0, write_req=0.
- FLUSH_CYCLES=3; taken BNE (1 vs 2), then taken BLTU on each of the next 4 cycles → first redirect, next 3 squashed, 4th redirects again.
- BLT with src1=0xFFFFFFFF, src2=1 → taken; BLTU with the same operands → not taken; JAL with rd=0 → write_req=0 and redirect still issued.
- Reset asserted for 1 cycle while flush_cnt=2 → all outputs 0; a taken BEQ presented with pc_d aligned after reset redirects without squash.
